// File: rtl/mole_spawner_pkg.sv
// Shared types and constants for the mole spawner: FSM encoding, default timing
// parameters, PRNG field positions and a popcount helper.
package mole_spawner_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StPick
  } state_e;

  localparam int unsigned GapBaseDef  = 8;
  localparam int unsigned LifeBaseDef = 16;
  localparam int unsigned RetryMaxDef = 4;

  // Bit-field positions inside the 32-bit PRNG word; each field is 4 bits wide.
  localparam int unsigned CandLsb = 0;
  localparam int unsigned LifeLsb = 16;
  localparam int unsigned GapLsb  = 24;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/mole_timer.sv
// Per-hole lifetime counter: holds the live flag for one hole and flags the
// tick that runs its lifetime down to zero.
module mole_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick,
  input  logic          clear,
  output logic          live,
  output logic          expire
);

  logic [CW-1:0] life_q, life_d;
  logic          live_q, live_d;

  assign expire = live_q & tick & (life_q == CW'(1));
  assign live   = live_q;

  always_comb begin
    life_d = life_q;
    live_d = live_q;
    if (clear) begin
      life_d = '0;
      live_d = 1'b0;
    end else if (load) begin
      life_d = load_val;
      live_d = 1'b1;
    end else if (live_q && tick && life_q != '0) begin
      life_d = life_q - CW'(1);
      if (life_q == CW'(1)) begin
        live_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      life_q <= '0;
      live_q <= 1'b0;
    end else begin
      life_q <= life_d;
      live_q <= live_d;
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Turns the PRNG stream into mole spawns, tracks live moles per hole and reports
// registered hit / whiff / escape / spawn-skip events.
module mole_spawner
  import mole_spawner_pkg::*;
#(
  parameter int unsigned N_HOLES   = 9,
  parameter int unsigned MAX_MOLES = 3,
  parameter int unsigned GAP_BASE  = GapBaseDef,
  parameter int unsigned LIFE_BASE = LifeBaseDef,
  parameter int unsigned RETRY_MAX = RetryMaxDef,
  parameter int unsigned CW        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        random,
  input  logic               tick,
  input  logic               game_en,
  input  logic [N_HOLES-1:0] hit,
  output logic [N_HOLES-1:0] mole,
  output logic               hit_pulse,
  output logic [3:0]         hit_cnt,
  output logic               whiff,
  output logic               escape,
  output logic               spawn_skip
);

  state_e        state_q, state_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [7:0]    retry_q, retry_d;

  logic [N_HOLES-1:0] load, clear, expire, hit_live;
  logic [15:0]        mole_pad, hit_pad;
  logic [3:0]         cand;
  logic               cand_ok, accept;
  logic [CW-1:0]      gap_reload, life_val;

  logic       hit_pulse_q, whiff_q, escape_q, spawn_skip_q, spawn_skip_d;
  logic [3:0] hit_cnt_q;
  logic       unused_random;

  assign cand          = random[CandLsb +: 4];
  assign gap_reload    = CW'(GAP_BASE) + CW'(random[GapLsb +: 4]);
  assign life_val      = CW'(LIFE_BASE) + CW'(random[LifeLsb +: 4]);
  assign unused_random = ^{random[31:28], random[23:20], random[15:4]};

  assign hit_live = hit & mole;

  always_comb begin
    mole_pad = '0;
    mole_pad[N_HOLES-1:0] = mole;
    hit_pad = '0;
    hit_pad[N_HOLES-1:0] = hit_live;
  end

  // Only holes empty in the current cycle are eligible, even if a hit clears one now.
  assign cand_ok = (32'(cand) < N_HOLES) && !mole_pad[cand];
  assign accept  = game_en && (state_q == StPick) && cand_ok;

  for (genvar i = 0; i < N_HOLES; i++) begin : g_hole
    assign load[i]  = accept && (cand == 4'(i));
    assign clear[i] = ~game_en | hit_live[i];

    mole_timer #(
      .CW(CW)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (load[i]),
      .load_val(life_val),
      .tick    (tick),
      .clear   (clear[i]),
      .live    (mole[i]),
      .expire  (expire[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    retry_d      = retry_q;
    spawn_skip_d = 1'b0;
    if (!game_en) begin
      state_d = StIdle;
      gap_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StGap;
          gap_d   = gap_reload;
        end
        StGap: begin
          if (tick) begin
            if (gap_q <= CW'(1)) begin
              if (32'(popcount16(mole_pad)) < MAX_MOLES) begin
                state_d = StPick;
                gap_d   = '0;
              end else begin
                gap_d = gap_reload;
              end
            end else begin
              gap_d = gap_q - CW'(1);
            end
          end
        end
        StPick: begin
          if (cand_ok) begin
            state_d = StGap;
            gap_d   = gap_reload;
            retry_d = '0;
          end else if (retry_q == 8'(RETRY_MAX - 1)) begin
            spawn_skip_d = 1'b1;
            state_d      = StGap;
            gap_d        = gap_reload;
            retry_d      = '0;
          end else begin
            retry_d = retry_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      gap_q        <= '0;
      retry_q      <= '0;
      hit_pulse_q  <= 1'b0;
      hit_cnt_q    <= '0;
      whiff_q      <= 1'b0;
      escape_q     <= 1'b0;
      spawn_skip_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      retry_q      <= retry_d;
      hit_pulse_q  <= game_en & (|hit_live);
      hit_cnt_q    <= game_en ? 4'(popcount16(hit_pad)) : 4'd0;
      whiff_q      <= game_en & (|(hit & ~mole));
      // A hole hit in its expiry cycle scores as a hit, not an escape.
      escape_q     <= game_en & (|(expire & ~hit_live));
      spawn_skip_q <= spawn_skip_d;
    end
  end

  assign hit_pulse  = hit_pulse_q;
  assign hit_cnt    = hit_cnt_q;
  assign whiff      = whiff_q;
  assign escape     = escape_q;
  assign spawn_skip = spawn_skip_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed self-checking bench for mole_spawner with hand-derived event timing.
module tb_mole_spawner;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] random;
  logic        tick;
  logic        game_en;
  logic [8:0]  hit;
  logic [8:0]  mole;
  logic        hit_pulse;
  logic [3:0]  hit_cnt;
  logic        whiff;
  logic        escape;
  logic        spawn_skip;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mole_spawner #(
    .N_HOLES  (9),
    .MAX_MOLES(3),
    .GAP_BASE (8),
    .LIFE_BASE(16),
    .RETRY_MAX(4),
    .CW       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .random    (random),
    .tick      (tick),
    .game_en   (game_en),
    .hit       (hit),
    .mole      (mole),
    .hit_pulse (hit_pulse),
    .hit_cnt   (hit_cnt),
    .whiff     (whiff),
    .escape    (escape),
    .spawn_skip(spawn_skip)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clear the board, then enable: one edge moves IDLE -> GAP with the gap from r.
  task automatic start_game(input logic [31:0] r);
    game_en = 1'b0;
    tick    = 1'b0;
    hit     = '0;
    step();
    random  = r;
    game_en = 1'b1;
    step();
  endtask

  task automatic tick_steps(input int n);
    tick = 1'b1;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; game_en = 1'b0; tick = 1'b0; hit = '0; random = '0;
    #12;
    total++;
    if (mole !== 9'h000) begin
      $display("FAIL reset_mole: got %h want %h", mole, 9'h000); bad++;
    end
    total++;
    if ({hit_pulse, hit_cnt, whiff, escape, spawn_skip} !== 8'h00) begin
      $display("FAIL reset_pulses: got %b want %b",
               {hit_pulse, hit_cnt, whiff, escape, spawn_skip}, 8'h00); bad++;
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_spawn_escape();
    int skips;
    start_game(32'h0000_0003);
    tick_steps(8);
    total++;
    if (mole !== 9'h000) begin
      $display("FAIL spawn_early: got %h want %h", mole, 9'h000); bad++;
    end
    step();
    total++;
    if (mole !== 9'h008) begin
      $display("FAIL spawn_hole3: got %h want %h", mole, 9'h008); bad++;
    end
    skips = 0;
    repeat (15) begin
      step();
      skips += int'(spawn_skip);
    end
    total++;
    if ({mole, escape} !== {9'h008, 1'b0}) begin
      $display("FAIL life_before_expiry: got %h/%b want 008/0", mole, escape); bad++;
    end
    step();
    total++;
    if ({mole, escape} !== {9'h000, 1'b1}) begin
      $display("FAIL escape: got %h/%b want 000/1", mole, escape); bad++;
    end
    total++;
    if (skips !== 1) begin
      $display("FAIL skip_while_occupied: got %0d want %0d", skips, 1); bad++;
    end
    tick = 1'b0;
    step();
    total++;
    if (escape !== 1'b0) begin
      $display("FAIL escape_one_cycle: got %b want %b", escape, 1'b0); bad++;
    end
  endtask

  task automatic test_hit();
    int seen;
    start_game(32'h0000_0003);
    tick_steps(9);
    tick_steps(4);
    hit = 9'h008;
    step();
    hit = '0;
    tick = 1'b0;
    total++;
    if ({hit_pulse, hit_cnt, mole, whiff, escape} !== {1'b1, 4'd1, 9'h000, 1'b0, 1'b0}) begin
      $display("FAIL hit_live: got p=%b c=%0d m=%h w=%b e=%b want p=1 c=1 m=000 w=0 e=0",
               hit_pulse, hit_cnt, mole, whiff, escape); bad++;
    end
    step();
    total++;
    if ({hit_pulse, hit_cnt} !== 5'b0) begin
      $display("FAIL hit_one_cycle: got %b/%0d want 0/0", hit_pulse, hit_cnt); bad++;
    end
    seen = 0;
    repeat (20) begin
      step();
      seen += int'(escape);
    end
    total++;
    if (seen !== 0) begin
      $display("FAIL no_escape_after_hit: got %0d want %0d", seen, 0); bad++;
    end
  endtask

  task automatic test_reset_mid();
    start_game(32'h0000_0003);
    tick_steps(9);
    tick = 1'b0;
    total++;
    if (mole !== 9'h008) begin
      $display("FAIL pre_reset_mole: got %h want %h", mole, 9'h008); bad++;
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({mole, hit_pulse, hit_cnt, whiff, escape, spawn_skip} !== 17'h0) begin
      $display("FAIL async_reset: got m=%h p=%b c=%0d w=%b e=%b s=%b want all 0",
               mole, hit_pulse, hit_cnt, whiff, escape, spawn_skip); bad++;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    total++;
    if ({mole, hit_pulse, hit_cnt, whiff, escape, spawn_skip} !== 17'h0) begin
      $display("FAIL reset_release: got m=%h p=%b c=%0d w=%b e=%b s=%b want all 0",
               mole, hit_pulse, hit_cnt, whiff, escape, spawn_skip); bad++;
    end
    tick_steps(8);
    total++;
    if (mole !== 9'h000) begin
      $display("FAIL idle_after_reset_gap: got %h want %h", mole, 9'h000); bad++;
    end
    step();
    total++;
    if (mole !== 9'h008) begin
      $display("FAIL idle_after_reset_spawn: got %h want %h", mole, 9'h008); bad++;
    end
  endtask

  task automatic test_skip();
    int skips;
    start_game(32'h0000_000F);
    tick_steps(8);
    tick  = 1'b0;
    skips = 0;
    repeat (3) begin
      step();
      skips += int'(spawn_skip);
    end
    total++;
    if (skips !== 0) begin
      $display("FAIL skip_early: got %0d want %0d", skips, 0); bad++;
    end
    step();
    total++;
    if ({spawn_skip, mole} !== {1'b1, 9'h000}) begin
      $display("FAIL skip_fourth_reject: got %b/%h want 1/000", spawn_skip, mole); bad++;
    end
    step();
    total++;
    if (spawn_skip !== 1'b0) begin
      $display("FAIL skip_one_cycle: got %b want %b", spawn_skip, 1'b0); bad++;
    end
    random = 32'h0000_0003;
    tick_steps(8);
    total++;
    if (mole !== 9'h000) begin
      $display("FAIL skip_gap_reload: got %h want %h", mole, 9'h000); bad++;
    end
    step();
    total++;
    if (mole !== 9'h008) begin
      $display("FAIL skip_then_spawn: got %h want %h", mole, 9'h008); bad++;
    end
  endtask

  task automatic test_hit_expire();
    // Hole 1 life 31, hole 3 spawned 9 ticks later with life 22: both expire together.
    start_game(32'h000F_0001);
    tick_steps(9);
    total++;
    if (mole !== 9'h002) begin
      $display("FAIL two_spawn_first: got %h want %h", mole, 9'h002); bad++;
    end
    random = 32'h0006_0003;
    tick_steps(9);
    total++;
    if (mole !== 9'h00A) begin
      $display("FAIL two_spawn_second: got %h want %h", mole, 9'h00A); bad++;
    end
    random = 32'h0000_000F;
    tick_steps(21);
    total++;
    if ({mole, escape} !== {9'h00A, 1'b0}) begin
      $display("FAIL pre_joint_expiry: got %h/%b want 00A/0", mole, escape); bad++;
    end
    hit = 9'h003;
    step();
    hit = '0;
    total++;
    if ({hit_pulse, hit_cnt, whiff, escape, mole} !== {1'b1, 4'd1, 1'b1, 1'b1, 9'h000}) begin
      $display("FAIL joint_events: got p=%b c=%0d w=%b e=%b m=%h want p=1 c=1 w=1 e=1 m=000",
               hit_pulse, hit_cnt, whiff, escape, mole); bad++;
    end
  endtask

  task automatic test_full_board();
    int escs;
    start_game(32'h000F_0000);
    tick_steps(9);
    random = 32'h000F_0001;
    tick_steps(9);
    random = 32'h000F_0002;
    tick_steps(9);
    total++;
    if (mole !== 9'h007) begin
      $display("FAIL three_live: got %h want %h", mole, 9'h007); bad++;
    end
    random = 32'h000F_0004;
    tick_steps(9);
    total++;
    if (mole !== 9'h007) begin
      $display("FAIL full_no_pick: got %h want %h", mole, 9'h007); bad++;
    end
    escs = 0;
    repeat (7) begin
      step();
      escs += int'(escape);
    end
    total++;
    if ({mole, escs[3:0]} !== {9'h006, 4'd1}) begin
      $display("FAIL full_reload_gap: got %h/%0d want 006/1", mole, escs); bad++;
    end
    step();
    total++;
    if (mole !== 9'h016) begin
      $display("FAIL reload_then_spawn: got %h want %h", mole, 9'h016); bad++;
    end
    game_en = 1'b0;
    hit     = 9'h003;
    step();
    hit = '0;
    total++;
    if ({mole, hit_pulse, hit_cnt, whiff, escape, spawn_skip} !== 17'h0) begin
      $display("FAIL disable_clears: got m=%h p=%b c=%0d w=%b e=%b s=%b want all 0",
               mole, hit_pulse, hit_cnt, whiff, escape, spawn_skip); bad++;
    end
    random  = 32'h0000_0003;
    game_en = 1'b1;
    tick    = 1'b0;
    step();
    tick_steps(8);
    total++;
    if (mole !== 9'h000) begin
      $display("FAIL idle_after_disable_gap: got %h want %h", mole, 9'h000); bad++;
    end
    step();
    total++;
    if (mole !== 9'h008) begin
      $display("FAIL idle_after_disable_spawn: got %h want %h", mole, 9'h008); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_spawn_escape();
    test_hit();
    test_reset_mid();
    test_skip();
    test_hit_expire();
    test_full_board();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
